// File: rtl/clk_slot_sched_pkg.sv
// Shared types and constants for the clock-slot scheduler and its round-robin picker.
package clk_slot_sched_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DIV_W  = 8;
    localparam int DEF_TO_MAX = 1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } slot_state_t;

    // Index width for a requester count; never below one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_slot_sched_if.sv
// Request/grant bundle between the GA compute units (master) and the slot scheduler (slave).
interface clk_slot_sched_if
    import clk_slot_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int DIV_W = DEF_DIV_W
);

    localparam int IW = idx_w(N_REQ);

    logic [DIV_W-1:0] div;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] en;
    logic [IW-1:0]    owner;
    logic             busy;
    logic             timeout;

    modport master (
        output div, req, done,
        input  grant, en, owner, busy, timeout
    );

    modport slave (
        input  div, req, done,
        output grant, en, owner, busy, timeout
    );

endinterface

// File: rtl/clk_slot_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping past the top.
module rr_pick
    import clk_slot_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IW   = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    idx,
    output logic [N_REQ-1:0] onehot
);

    localparam int IW1 = IW + 1;
    localparam logic [IW:0] NQ = IW1'(N_REQ);

    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    off;
    logic [IW:0]      sum;

    assign rot = N_REQ'({req, req} >> ptr);

    // The lowest set bit of the rotated vector is the distance from ptr to the winner.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IW'(i);
            end
        end
    end

    assign sum    = {1'b0, ptr} + {1'b0, off};
    assign idx    = (sum >= NQ) ? IW'(sum - NQ) : sum[IW-1:0];
    assign valid  = |req;
    assign onehot = valid ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/clk_slot_sched.sv
// Clock-slot scheduler: divides clk into ticks and hands exclusive enable slots to GA units round-robin.
// Optional slot watchdog is compiled in with CLK_SLOT_SCHED_TIMEOUT_EN.
module clk_slot_sched
    import clk_slot_sched_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DIV_W  = DEF_DIV_W,
    parameter int TO_MAX = DEF_TO_MAX
) (
    input  logic            clk,
    input  logic            rst,
    clk_slot_sched_if.slave bus
);

    localparam int IW = idx_w(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TO_MAX < 2) begin : g_param_check
        $error("clk_slot_sched: unsupported parameter set");
    end

    slot_state_t      state, state_d;
    logic [DIV_W-1:0] cnt, div_q;
    logic             tick;
    logic [IW-1:0]    ptr, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] en_q, en_d;
    logic             busy_q, busy_d;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             owner_exit;
    logic             force_exit;

    assign tick = (cnt == div_q);

    // Period length is latched only at wrap so a mid-period div write never shortens the running period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            div_q <= bus.div;
        end else if (tick) begin
            cnt   <= '0;
            div_q <= bus.div;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign owner_exit = bus.done[owner_q] | ~bus.req[owner_q];

`ifdef CLK_SLOT_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TO_MAX);

    logic [TW-1:0] tcnt;
    logic          timeout_q;

    assign force_exit = (state == BUSY) && (tcnt == TW'(TO_MAX - 1));

    // Slot age is held at zero outside BUSY; a genuine release on the limit cycle suppresses the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt      <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt      <= (state == BUSY) ? tcnt + 1'b1 : '0;
            timeout_q <= force_exit & ~owner_exit;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign force_exit  = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            owner_q <= '0;
            grant_q <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (tick && pick_valid) state_d = BUSY;
            BUSY:    if (owner_exit || force_exit) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Computes the values the registered outputs take at the next edge.
    always_comb begin
        ptr_d   = ptr;
        owner_d = owner_q;
        grant_d = grant_q;
        en_d    = '0;
        busy_d  = busy_q;
        case (state)
            IDLE: begin
                if (tick && pick_valid) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                end
            end
            BUSY: begin
                if (owner_exit || force_exit) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if (tick) begin
                    en_d = grant_q;
                end
            end
            RELEASE: begin
                ptr_d = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.en    = en_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_clk_slot_sched.sv
// Randomized self-checking bench for clk_slot_sched against a slot-level reference model.
// Build with CLK_SLOT_SCHED_TIMEOUT_EN to also exercise the watchdog (TO_MAX=20).
module tb_clk_slot_sched;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TOM = 20;
`ifdef CLK_SLOT_SCHED_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    localparam int M_FREE = 0;
    localparam int M_HOLD = 1;
    localparam int M_COOL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clk_slot_sched_if #(.N_REQ(N), .DIV_W(DW)) bus ();

    clk_slot_sched #(.N_REQ(N), .DIV_W(DW), .TO_MAX(TOM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // reference model: slot mode, owner, round-robin pointer, slot age and next tick cycle
    int cyc = 0;
    int next_tick = 0;
    int mode = M_FREE;
    int m_owner = 0;
    int m_ptr = 0;
    int m_age = 0;
    logic [N-1:0] exp_en = '0;
    bit exp_to = 1'b0;

    int ens_seen;
    bit dropped;
    bit s_rst;
    int s_div;
    logic [N-1:0] s_req, s_done;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit r, input int d, input logic [N-1:0] rq, input logic [N-1:0] dn);
        rst      = r;
        bus.div  = DW'(d);
        bus.req  = rq;
        bus.done = dn;
    endtask

    task automatic modelEdge(input bit r, input int d, input logic [N-1:0] rq, input logic [N-1:0] dn);
        bit tick, leaves, forced;
        exp_en = '0;
        exp_to = 1'b0;
        if (r) begin
            mode      = M_FREE;
            m_ptr     = 0;
            m_owner   = 0;
            next_tick = cyc + 1 + d;
        end else begin
            tick = (cyc == next_tick);
            if (tick) next_tick = cyc + 1 + d;
            if (mode == M_HOLD) begin
                leaves = dn[m_owner] || !rq[m_owner];
                forced = TO_ON && (m_age == TOM - 1);
                if (leaves || forced) begin
                    mode   = M_COOL;
                    exp_to = forced && !leaves;
                end else begin
                    if (tick) exp_en[m_owner] = 1'b1;
                    m_age++;
                end
            end else if (mode == M_COOL) begin
                m_ptr = (m_owner + 1) % N;
                mode  = M_FREE;
            end else if (tick && rq != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                mode  = M_HOLD;
                m_age = 0;
            end
        end
    endtask

    task automatic stepCycle();
        bit r;
        int d;
        logic [N-1:0] rq, dn;
        logic [N-1:0] exp_grant;
        r  = rst;
        d  = int'(bus.div);
        rq = bus.req;
        dn = bus.done;
        @(posedge clk);
        modelEdge(r, d, rq, dn);
        cyc++;
        #1;
        exp_grant = (mode == M_HOLD) ? (N'(1) << m_owner) : '0;
        checkOutput("grant",   32'(bus.grant),   32'(exp_grant));
        checkOutput("en",      32'(bus.en),      32'(exp_en));
        checkOutput("owner",   32'(bus.owner),   32'(m_owner));
        checkOutput("busy",    32'(bus.busy),    32'(mode == M_HOLD));
        checkOutput("timeout", 32'(bus.timeout), 32'(exp_to));
        checkOutput("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        checkOutput("en_in_grant",   32'((bus.en & ~bus.grant) == '0), 32'd1);
    endtask

    initial begin
        // reset held three cycles with every unit requesting
        applyStimulus(1'b1, 0, 4'b1111, 4'b0000);
        repeat (3) stepCycle();
        applyStimulus(1'b0, 0, 4'b1111, 4'b0000);
        repeat (4) stepCycle();

        // single requester at div=3: steady grant, enable every fourth cycle
        applyStimulus(1'b0, 3, 4'b0100, 4'b0000);
        repeat (32) stepCycle();

        // all requesting, each owner releases after two enables
        s_req = 4'b1111;
        ens_seen = 0;
        for (int i = 0; i < 70; i++) begin
            s_done = '0;
            if (mode == M_HOLD && ens_seen >= 2) s_done[m_owner] = 1'b1;
            applyStimulus(1'b0, 1, s_req, s_done);
            stepCycle();
            if (mode != M_HOLD) ens_seen = 0;
            else if (exp_en != '0) ens_seen++;
        end

        // period change 3 -> 1 part way through a period
        applyStimulus(1'b0, 3, 4'b0100, 4'b0000);
        repeat (9) stepCycle();
        applyStimulus(1'b0, 1, 4'b0100, 4'b0000);
        repeat (16) stepCycle();

        // owner 1 drops its request on a tick; stray done[3] pulses while it holds
        dropped = 1'b0;
        for (int i = 0; i < 50; i++) begin
            s_req  = dropped ? 4'b1101 : 4'b0010;
            s_done = (i % 5 == 0) ? 4'b1000 : 4'b0000;
            if (!dropped && mode == M_HOLD && m_owner == 1 && m_age > 6 && cyc == next_tick) begin
                dropped = 1'b1;
                s_req   = 4'b1101;
            end
            applyStimulus(1'b0, 2, s_req, s_done);
            stepCycle();
        end

        // owners never release at div=0 (watchdog forces release when built in)
        applyStimulus(1'b0, 0, 4'b0011, 4'b0000);
        repeat (70) stepCycle();

        // release coinciding with the watchdog limit cycle
        for (int i = 0; i < 60; i++) begin
            s_done = '0;
            if (mode == M_HOLD && m_age == TOM - 1) s_done[m_owner] = 1'b1;
            applyStimulus(1'b0, 0, 4'b0011, s_done);
            stepCycle();
        end

        // random traffic with occasional mid-slot resets and divider changes
        s_div = 1;
        s_req = 4'b1010;
        for (int i = 0; i < 500; i++) begin
            s_rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) s_div = $urandom_range(0, 3);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) s_req[b] = ~s_req[b];
            end
            s_done = '0;
            if ($urandom_range(0, 5) == 0) s_done[$urandom_range(0, N - 1)] = 1'b1;
            if (mode == M_HOLD && $urandom_range(0, 4) == 0) s_done[m_owner] = 1'b1;
            applyStimulus(s_rst, s_div, s_req, s_done);
            stepCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/clk_slot_sched.md
Name: clk_slot_sched

Overview:
- Shares the single system clock `clk` between up to N_REQ GA compute units (fitness, crossover, mutation, RNG reseed).
- Divides `clk` into a programmable tick rate and grants exclusive "slots" round-robin.
- While a unit holds a slot it receives one-cycle clock-enable strobes on each tick; no gated clocks.
- Sits between the top-level clock source and the GA engine units.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DIV_W, 8, width of divider period input
- TO_MAX, 1000, slot watchdog limit in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- div  in  DIV_W  tick period minus 1 (0 = tick every cycle)
- req  in  N_REQ  level request per unit
- done  in  N_REQ  one-cycle release pulse per unit
- grant  out  N_REQ  one-hot slot owner, level, registered
- en  out  N_REQ  one-cycle clock-enable strobe to owner, registered
- owner  out  $clog2(N_REQ)  index of current/last owner
- busy  out  1  high while in BUSY
- timeout  out  1  one-cycle watchdog pulse

Behaviour:
- Reset (sync, rst=1 at edge): cnt=0, div_q=div, state=IDLE, ptr=0; all outputs 0.
- Reset mid-slot: grant and en drop on that edge; no done required.
- Divider:
  - cnt counts 0..div_q; tick=1 when cnt==div_q, then cnt wraps to 0.
  - div_q reloads from div only at wrap; a div change mid-period never truncates the period.
  - div=0 gives tick every cycle. Divider runs in all states.
- FSM IDLE / BUSY / RELEASE:
  - IDLE: on tick with req!=0, pick the first set req bit scanning from ptr upward with wrap.
    - Next edge: grant=onehot(pick), owner=pick, busy=1, state=BUSY.
    - No tick or req=0: stay IDLE.
  - BUSY: grant held. On each tick, en[owner]=1 for one cycle (registered, visible the cycle after tick).
    - Exit to RELEASE when done[owner]=1 or req[owner]=0.
    - If the exit condition coincides with a tick, no en is issued.
    - done on non-owner bits is ignored.
  - RELEASE (1 cycle): grant=0, busy=0, en=0, ptr=(owner+1) mod N_REQ, then IDLE.
- Latency:
  - req to grant: ≥1 cycle; grant appears on the edge after the arbitrating tick.
  - First en: next tick after grant, never the same cycle as grant rising.
- Bus rules:
  - Back-to-back slots are separated by ≥1 idle cycle (RELEASE) plus wait for the next tick.
  - grant is always one-hot or zero; en is a subset of grant.
- Fairness: a continuously requesting unit waits at most N_REQ-1 slots.

Optional Feature:
- Macro: CLK_SLOT_SCHED_TIMEOUT_EN
- With it:
  - A cycle counter clears on entering BUSY and increments each BUSY cycle.
  - At TO_MAX-1, BUSY is forced to RELEASE and timeout pulses 1 cycle, concurrent with entering RELEASE.
  - ptr advances past the owner as normal.
  - A genuine done in the same cycle wins; no timeout pulse.
- Without it: counter logic absent; timeout tied 0; BUSY held indefinitely.

Decomposition:
- Package clk_slot_sched_pkg: state enum (IDLE, BUSY, RELEASE), IDX_W = $clog2(N_REQ) helper, default N_REQ/DIV_W constants.
- One sub-module, rr_pick: combinational round-robin picker taking req and ptr, returning valid, index and one-hot.
  - Reusable by later GA arbiters.
  - Divider and FSM stay in the top module.

Test Plan:
- rst=1 for 3 cycles with req=4'b1111: grant, en, busy, timeout all 0; after release, first grant=4'b0001 on the edge after the first tick.
- div=3, req=4'b0100 held, no done: en[2] pulses exactly every 4 cycles; grant=4'b0100 steady; owner=2.
- req=4'b1111, each owner pulses done after 2 ens: grant sequence 0001,0010,0100,1000,0001; one RELEASE cycle of grant=0 between each.
- div changed 3→1 mid-period: current period stays 4 cycles; subsequent ticks are every 2 cycles.
- Owner 1 drops req on a tick cycle: no en that cycle; RELEASE next; ptr=2; stray done[3] during BUSY ignored.
- With CLK_SLOT_SCHED_TIMEOUT_EN, TO_MAX=20, div=0, owner never done: timeout pulses once 20 cycles after busy rises; grant moves to next requester.
- Same setup with done on the timeout cycle: timeout stays 0.
